// File: rtl/shift_seq_141.sv
// Sequencer for a chain of mc10141 universal shift registers: issues an optional
// LOAD cycle and then `count` shift edges, driving the shared mode lines and serial fills.
module shift_seq_141 #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic             load_first,
  input  logic             dir,
  input  logic [1:0]       fill,
  input  logic [CNT_W-1:0] count,
  input  logic             bit0_q,
  input  logic             bitn_q,
  output logic             op2,
  output logic             op1,
  output logic             shft0in,
  output logic             shftn_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  // Both chain ends must be distinct cells and the counter needs at least one bit.
  if (WIDTH < 2 || CNT_W < 1) begin : g_param_chk
    $error("shift_seq_141: WIDTH must be >= 2 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SHIFTR = 2'b01;
  localparam logic [1:0] OP_SHIFTL = 2'b10;
  localparam logic [1:0] OP_HOLD   = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [1:0]       fill_q, fill_d;
  logic             fill_bit;

  // State and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  // Serial fill value for the end the data is moving away from.
  always_comb begin
    fill_bit = 1'b0;
    case (fill_q)
      2'b00:   fill_bit = 1'b0;
      2'b01:   fill_bit = 1'b1;
      2'b10:   fill_bit = dir_q ? bit0_q : bitn_q;
      default: fill_bit = dir_q ? bitn_q : bit0_q;
    endcase
  end

  // Next state and Moore output decode.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    {op2, op1} = OP_HOLD;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    shft0in  = 1'b0;
    shftn_in = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          dir_d  = dir;
          fill_d = fill;
          rem_d  = count;
          if (load_first)                 state_d = S_LOAD;
          else if (count == CNT_W'(0))    state_d = S_DONE;
          else                            state_d = S_SHIFT;
        end
      end
      S_LOAD: begin
        {op2, op1} = OP_LOAD;
        busy       = 1'b1;
        state_d    = (rem_q == CNT_W'(0)) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        {op2, op1} = dir_q ? OP_SHIFTL : OP_SHIFTR;
        busy       = 1'b1;
        if (dir_q) shft0in  = fill_bit;
        else       shftn_in = fill_bit;
        // Guard against wrap: a zero count never stays in SHIFT.
        if (rem_q == CNT_W'(0)) begin
          state_d = S_DONE;
        end else begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign remaining = rem_q;

endmodule

// File: tb/tb_shift_seq_141.sv
// Bench for shift_seq_141: 8-bit chain model, transaction-level expected-cycle queue,
// directed scenarios with literal expectations, then randomized requests.
module tb_shift_seq_141;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic       load_first;
  logic       dir;
  logic [1:0] fill;
  logic [5:0] count;
  logic       bit0_q, bitn_q;
  logic       op2, op1;
  logic       shft0in, shftn_in;
  logic       busy, done;
  logic [5:0] remaining;

  logic [7:0] d_val = 8'h00;
  logic [7:0] chain = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;

  shift_seq_141 #(.WIDTH(8), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .load_first(load_first), .dir(dir), .fill(fill), .count(count),
    .bit0_q(bit0_q), .bitn_q(bitn_q), .op2(op2), .op1(op1),
    .shft0in(shft0in), .shftn_in(shftn_in), .busy(busy), .done(done),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Chain of two 4-bit devices seen as one byte; byte bit 7 is chain bit 0.
  assign bit0_q = chain[7];
  assign bitn_q = chain[0];
  always @(posedge clk) begin
    case ({op2, op1})
      2'b00:   chain <= d_val;
      2'b01:   chain <= {chain[6:0], shftn_in};
      2'b10:   chain <= {shft0in, chain[7:1]};
      default: chain <= chain;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic fill_fn(input logic dr, input logic [1:0] fl,
                                   input logic b0, input logic bn);
    case (fl)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return dr ? b0 : bn;
      default: return dr ? bn : b0;
    endcase
  endfunction

  // Reference model: one record per expected cycle of the accepted request.
  typedef struct {
    logic [1:0] op;
    logic [5:0] rem;
    logic       dn;
    logic       sh;
  } rec_t;

  rec_t       q[$];
  logic       m_dir;
  logic [1:0] m_fill;
  logic [7:0] exp_chain;

  always @(negedge clk) begin
    rec_t cur;
    logic idle, f;
    logic [7:0] v;
    if (!rst_n) q.delete();
    idle = (q.size() == 0);
    if (idle) cur = '{op: 2'b11, rem: 6'd0, dn: 1'b0, sh: 1'b0};
    else      cur = q[0];
    f = fill_fn(m_dir, m_fill, chain[7], chain[0]);
    chk("op",        {30'd0, op2, op1}, {30'd0, cur.op});
    chk("ready",     32'(ready), 32'(idle));
    chk("busy",      32'(busy), 32'(!idle && !cur.dn));
    chk("done",      32'(done), 32'(cur.dn));
    chk("remaining", 32'(remaining), 32'(cur.rem));
    chk("shft0in",   32'(shft0in),  32'(cur.sh && m_dir && f));
    chk("shftn_in",  32'(shftn_in), 32'(cur.sh && !m_dir && f));
    if (cur.dn) chk("chain_at_done", 32'(chain), 32'(exp_chain));

    if (rst_n) begin
      if (!idle) begin
        void'(q.pop_front());
      end else if (start) begin
        m_dir  = dir;
        m_fill = fill;
        v = load_first ? d_val : chain;
        for (int k = 0; k < int'(count); k++) begin
          f = fill_fn(dir, fill, v[7], v[0]);
          if (!dir) v = 8'((v << 1) | 8'(f));
          else      v = (v >> 1) | (8'(f) << 7);
        end
        exp_chain = v;
        if (load_first) q.push_back('{op: 2'b00, rem: count, dn: 1'b0, sh: 1'b0});
        for (int k = int'(count); k >= 1; k--)
          q.push_back('{op: dir ? 2'b10 : 2'b01, rem: 6'(k), dn: 1'b0, sh: 1'b1});
        q.push_back('{op: 2'b11, rem: 6'd0, dn: 1'b1, sh: 1'b0});
      end
    end
  end

  // Issue one request from posedge+1; optionally retry start while the request runs.
  task automatic req(input logic lf, input logic dr, input logic [1:0] fl,
                     input logic [5:0] cn, input logic [7:0] dv, input logic extra,
                     output int lat);
    chk("ready_before_req", 32'(ready), 32'd1);
    d_val = dv; load_first = lf; dir = dr; fill = fl; count = cn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (extra) begin
      start = 1'b1; dir = !dr; fill = ~fl; count = 6'd7; load_first = 1'b1;
    end
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("latency", 32'(lat + 1), 32'(int'(lf) + int'(cn) + 1));
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; load_first = 1'b0; dir = 1'b0; fill = 2'b00; count = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op",   {30'd0, op2, op1}, 32'd3);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_rem",   32'(remaining), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a shift run.
    d_val = 8'h81; load_first = 1'b1; dir = 1'b0; fill = 2'b00; count = 6'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_op_shiftr", {30'd0, op2, op1}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_op",    {30'd0, op2, op1}, 32'd3);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_rem",   32'(remaining), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    req(1'b1, 1'b0, 2'b00, 6'd0, 8'h81, 1'b0, lat);
    chk("load_only_chain", 32'(chain), 32'h81);
    req(1'b1, 1'b0, 2'b00, 6'd3, 8'h81, 1'b0, lat);
    chk("shiftr3_chain", 32'(chain), 32'h08);
    req(1'b1, 1'b1, 2'b11, 6'd1, 8'h81, 1'b0, lat);
    chk("rotl_chain", 32'(chain), 32'hC0);
    req(1'b1, 1'b1, 2'b10, 6'd3, 8'h80, 1'b0, lat);
    chk("sign_chain", 32'(chain), 32'hF0);
    req(1'b0, 1'b0, 2'b00, 6'd0, 8'h00, 1'b1, lat);
    chk("noop_chain", 32'(chain), 32'hF0);
    req(1'b1, 1'b0, 2'b01, 6'd4, 8'h81, 1'b1, lat);
    chk("retry_busy_chain", 32'(chain), 32'h1F);
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic; d only changes while idle so a load sees the accepted value.
    for (int i = 0; i < 2500; i++) begin
      if (ready) d_val = 8'($urandom);
      start      = ($urandom_range(0, 3) == 0);
      load_first = 1'($urandom);
      dir        = 1'($urandom);
      fill       = 2'($urandom);
      count      = ($urandom_range(0, 19) == 0) ? 6'd63 : 6'($urandom_range(0, 9));
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
